// File: rtl/data_mem_if.sv
// CPU data-port bus between a requester (master) and the data memory responder (slave).
// One request at a time over valid/ready, answered by a single-cycle response strobe.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-port memory responder: accepts one byte-lane-aware load/store, inserts wait states,
// accesses a word-organised RAM and returns extended load data or a store acknowledge.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int unsigned IdxW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RangeBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WaitInit   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [32:0] req_offset;
  logic [31:0] addr_off;
  logic [IdxW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] word_q;
  logic [31:0] byte_sel, half_sel;
  logic        unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = bus.req_valid && (state_q == StIdle);

  // 33-bit subtract so addresses below BASE_ADDR borrow into bit 32 instead of wrapping.
  always_comb begin
    req_offset = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    req_err    = req_offset[32] || (req_offset >= RangeBytes);
    case (bus.req_funct3)
      3'b000:  ;
      3'b001:  if (bus.req_addr[0]) req_err = 1'b1;
      3'b010:  if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      3'b100:  if (bus.req_we) req_err = 1'b1;
      3'b101:  if (bus.req_we || bus.req_addr[0]) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAccess;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      err_q    <= req_err;
    end
  end

  assign addr_off         = addr_q - BASE_ADDR;
  assign idx              = addr_off[IdxW+1:2];
  assign unused_addr_bits = ^{addr_off[31:IdxW+2], addr_off[1:0]};

  // Lane enables and store data replicated across lanes so only the enable picks the target.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
    endcase
  end

  // RAM: not reset; write and synchronous read both happen on the ACCESS edge.
  always_ff @(posedge clk) begin
    if (state_q == StAccess) begin
      if (we_q && !err_q) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
      word_q <= mem[idx];
    end
  end

  assign byte_sel = word_q >> {addr_q[1:0], 3'b000};
  assign half_sel = word_q >> {addr_q[1], 4'b0000};

  // Output logic
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StResp);
    bus.resp_err   = (state_q == StResp) && err_q;
    bus.resp_rdata = 32'h0;
    if ((state_q == StResp) && !we_q && !err_q) begin
      case (funct3_q)
        3'b000:  bus.resp_rdata = {{24{byte_sel[7]}}, byte_sel[7:0]};
        3'b001:  bus.resp_rdata = {{16{half_sel[15]}}, half_sel[15:0]};
        3'b010:  bus.resp_rdata = word_q;
        3'b100:  bus.resp_rdata = {24'h0, byte_sel[7:0]};
        3'b101:  bus.resp_rdata = {16'h0, half_sel[15:0]};
        default: bus.resp_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases plus randomized traffic checked
// against an array-based memory model; a negedge monitor checks data, error and latency.
module tb_data_mem_responder;

  localparam int          WS    = 2;
  localparam longint      DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          last_accept;
  exp_t        sb[$];
  logic [31:0] mdl [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    longint off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= 4 * DEPTH) return 1'b1;
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return (a % 2) != 0;
      3'd2:    return (a % 4) != 0;
      3'd4:    return we;
      3'd5:    return we || ((a % 2) != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int w = int'((a - BASE) / 4);
    return mdl.exists(w) ? mdl[w] : 32'h0;
  endfunction

  // Applies the access to the model and returns the expected response data.
  function automatic logic [31:0] model_access(input logic we, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] wd);
    int          w    = int'((a - BASE) / 4);
    int          sh   = int'(a % 4) * 8;
    logic [31:0] word = model_word(a);
    logic [31:0] v;
    logic [31:0] mask;
    if (we) begin
      if (f3 == 3'd2) word = wd;
      else begin
        mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
        word = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end
      mdl[w] = word;
      return 32'h0;
    end
    v = word >> sh;
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: ;
    endcase
    return v;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold = 1'b0);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no req_ready expected req_ready within 50 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_accept = cyc;
    e.err   = model_err(we, f3, a);
    e.rdata = e.err ? 32'h0 : model_access(we, f3, a, wd);
    e.cyc   = cyc + WS + 1;
    sb.push_back(e);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
        chk("resp_latency", cyc, e.cyc);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  {31'h0, bus.req_ready},  32'h1);
    chk({tag, "_resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata,          32'h0);
    chk({tag, "_resp_err"},   {31'h0, bus.resp_err},   32'h0);
  endtask

  initial begin
    int a0, a1, a2;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Word store/load
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    // Byte merge into a word, halfword load
    issue(1'b1, 3'd2, 32'h20, 32'h11223344);
    issue(1'b1, 3'd0, 32'h21, 32'h000000AA);
    issue(1'b0, 3'd2, 32'h20, 32'h0);
    issue(1'b0, 3'd1, 32'h22, 32'h0);
    // Sign vs zero extension
    issue(1'b1, 3'd0, 32'h30, 32'h00000080);
    issue(1'b0, 3'd0, 32'h30, 32'h0);
    issue(1'b0, 3'd4, 32'h30, 32'h0);
    issue(1'b1, 3'd1, 32'h32, 32'h00008001);
    issue(1'b0, 3'd1, 32'h32, 32'h0);
    issue(1'b0, 3'd5, 32'h32, 32'h0);
    drain();

    // Errors: misaligned, out of range (word 0 must survive), illegal funct3, below-range wrap
    issue(1'b1, 3'd2, 32'h0, 32'h12345678);
    issue(1'b0, 3'd2, 32'h02, 32'h0);
    issue(1'b1, 3'd2, 32'h1000, 32'hCAFEF00D);
    issue(1'b0, 3'd2, 32'h0, 32'h0);
    issue(1'b1, 3'd4, 32'h8, 32'h1);
    issue(1'b0, 3'd3, 32'h8, 32'h0);
    issue(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0);
    issue(1'b0, 3'd0, 32'h0FFF, 32'h0);
    drain();

    // Back-to-back requests with req_valid held high throughout
    issue(1'b1, 3'd2, 32'h50, 32'hA5A5A5A5, 1'b1);
    a0 = last_accept;
    issue(1'b1, 3'd0, 32'h51, 32'h0000003C, 1'b1);
    a1 = last_accept;
    issue(1'b0, 3'd2, 32'h50, 32'h0, 1'b0);
    a2 = last_accept;
    chk("throughput_1", a1 - a0, WS + 3);
    chk("throughput_2", a2 - a1, WS + 3);
    drain();

    // Reset during WAIT drops the store and issues no response
    issue(1'b1, 3'd2, 32'h40, 32'h00000009);
    drain();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h00000005;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(1'b0, 3'd2, 32'h40, 32'h0);
    drain();

    // Randomized traffic over a pre-written 16-word window plus out-of-range addresses
    for (int i = 0; i < 16; i++) issue(1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 32'h1000 + 32'($urandom_range(0, 15)) : 32'hFFFFFFF0;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
